// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the EX-stage branch resolve unit.
package branch_resolve_unit_pkg;

    typedef enum logic [1:0] {
        BRANCH_NONE,
        BRANCH_COND,
        BRANCH_JAL,
        BRANCH_JALR
    } branch_type_t;

    typedef enum logic {
        BR_IDLE,
        BR_REDIRECT
    } branch_state_t;

    localparam logic [31:0] INSN_ALIGN_MASK = 32'h3;

endpackage

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps in EX: decides taken, computes the target, holds the
// redirect until fetch accepts it, and flags misaligned taken targets.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  branch_type_t     branch_type_i,
    input  logic             cmp_res_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      rs1_i,
    output logic [31:0]      link_pc_o,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [31:0]      misalign_addr_o,
    output logic [CNT_W-1:0] taken_count_o
);

    branch_state_t    state_q, state_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      misalign_addr_q, misalign_addr_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic             taken;
    logic [31:0]      target;
    logic             accept;

    assign ready_o          = (state_q == BR_IDLE);
    assign redirect_valid_o = (state_q == BR_REDIRECT);
    assign flush_o          = (state_q == BR_REDIRECT);
    assign link_pc_o        = pc_i + 32'd4;
    assign redirect_pc_o    = redirect_pc_q;
    assign misalign_o       = misalign_q;
    assign misalign_addr_o  = misalign_addr_q;
    assign taken_count_o    = taken_count_q;

    assign accept = valid_i & ready_o & (branch_type_i != BRANCH_NONE);

    always_comb begin
        taken  = 1'b0;
        target = pc_i + imm_i;
        case (branch_type_i)
            BRANCH_COND: taken = cmp_res_i;
            BRANCH_JAL:  taken = 1'b1;
            BRANCH_JALR: begin
                taken  = 1'b1;
                target = (rs1_i + imm_i) & ~32'h1;
            end
            default:     taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        redirect_pc_d   = redirect_pc_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        taken_count_d   = taken_count_q;
        case (state_q)
            BR_IDLE: begin
                if (accept && taken) begin
                    if ((target & INSN_ALIGN_MASK) != 32'h0) begin
                        misalign_d      = 1'b1;
                        misalign_addr_d = target;
                    end else begin
                        redirect_pc_d = target;
                        taken_count_d = taken_count_q + CNT_W'(1);
                        state_d       = BR_REDIRECT;
                    end
                end
            end
            BR_REDIRECT: begin
                // Younger valid_i is never taken here, even on the handshake cycle.
                if (redirect_ready_i) begin
                    state_d = BR_IDLE;
                end
            end
            default: state_d = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= BR_IDLE;
            redirect_pc_q   <= 32'h0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= 32'h0;
            taken_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            redirect_pc_q   <= redirect_pc_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            taken_count_q   <= taken_count_d;
        end
    end

endmodule
